// File: rtl/cpu_types_pkg.sv
// Shared CPU types: MSI line states, dcache address layout, snoop FSM states.
// Also carries the MSI downgrade rule used by the snoop responder.
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        I = 2'b00,
        S = 2'b01,
        M = 2'b10
    } msi_t;

    // 8-set, 2-word-block geometry
    typedef struct packed {
        logic [25:0] tag;
        logic [2:0]  idx;
        logic        blkoff;
        logic [1:0]  bytoff;
    } dcache_addr_t;

    typedef enum logic [1:0] {
        SNP_IDLE,
        SNP_SUPPLY,
        SNP_UPDATE,
        SNP_HOLD
    } snoop_state_t;

    // Invalidate always wins; otherwise M drops to S.
    function automatic msi_t snoop_next_state(msi_t cur, logic inv);
        if (inv)
            return I;
        if (cur == M)
            return S;
        return cur;
    endfunction

endpackage

// File: rtl/dcache_snoop_responder_if.sv
// Per-core slot of the cache-control bus.
// master: snoop responder side; slave: coherence/bus controller side.
interface dcache_snoop_responder_if;
    import cpu_types_pkg::*;

    logic  ccwait;
    logic  ccinv;
    word_t ccsnoopaddr;
    logic  ccwrite;
    logic  cctrans;
    logic  dWEN;
    logic  dREN;
    word_t daddr;
    word_t dstore;
    logic  dwait;

    modport master (
        input  ccwait, ccinv, ccsnoopaddr, dwait,
        output ccwrite, cctrans, dWEN, dREN, daddr, dstore
    );

    modport slave (
        output ccwait, ccinv, ccsnoopaddr, dwait,
        input  ccwrite, cctrans, dWEN, dREN, daddr, dstore
    );

endinterface

// File: rtl/snoop_tag_match.sv
// WAYS-wide tag compare for a snooped address; lowest valid matching way wins.
// Ports: i_tag, way_tag, way_state in; o_hit, o_way, o_state out.
module snoop_tag_match
    import cpu_types_pkg::*;
#(
    parameter int WAYS = 2,
    parameter int TW   = 26,
    parameter int WW   = 1
) (
    input  logic [TW-1:0]            i_tag,
    input  logic [WAYS-1:0][TW-1:0] way_tag,
    input  logic [WAYS-1:0][1:0]    way_state,
    output logic                     o_hit,
    output logic [WW-1:0]            o_way,
    output msi_t                     o_state
);

    // Scan high to low so the lowest matching way is the last writer.
    always_comb begin
        o_hit   = 1'b0;
        o_way   = '0;
        o_state = I;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (way_tag[w] == i_tag && way_state[w] != I) begin
                o_hit   = 1'b1;
                o_way   = WW'(w);
                o_state = msi_t'(way_state[w]);
            end
        end
    end

endmodule

// File: rtl/dcache_snoop_responder.sv
// Snooped side of MSI coherence for one dcache: lookup, M supply, downgrade.
// Ports: CLK/nRST, bus (if master), req_* from dcache, lookup and update ports.
module dcache_snoop_responder
    import cpu_types_pkg::*;
#(
    parameter int SETS = 8,
    parameter int WAYS = 2,
    localparam int IW = $clog2(SETS),
    localparam int WW = (WAYS > 1) ? $clog2(WAYS) : 1,
    localparam int TW = 29 - IW
) (
    input  logic                          CLK,
    input  logic                          nRST,
    dcache_snoop_responder_if.master      bus,
    input  logic                          req_dWEN,
    input  logic                          req_dREN,
    input  logic                          req_cctrans,
    input  logic                          req_ccwrite,
    input  word_t                         req_daddr,
    input  word_t                         req_dstore,
    output logic                          req_dwait,
    output logic [IW-1:0]                 snp_idx,
    input  logic [WAYS-1:0][TW-1:0]       way_tag,
    input  logic [WAYS-1:0][1:0]          way_state,
    input  logic [WAYS-1:0][1:0][31:0]    way_data,
    output logic                          upd_en,
    output logic [IW-1:0]                 upd_idx,
    output logic [WW-1:0]                 upd_way,
    output logic [1:0]                    upd_state
);

    snoop_state_t  r_state;
    logic [WW-1:0] r_way;
    logic [IW-1:0] r_idx;
    msi_t          r_msi;
    word_t         r_word;
    word_t         r_addr;
    logic          r_inv;
    logic          r_upd_en;
    msi_t          r_upd_state;

    logic          w_hit;
    logic [WW-1:0] w_way;
    msi_t          w_msi;
    logic [TW-1:0] w_tag;
    word_t         w_word;
    logic          w_hit_m;
    logic          w_snooped;
    logic          w_supply;
    logic          w_inv_acc;

    assign snp_idx = bus.ccsnoopaddr[IW+2:3];
    assign w_tag   = bus.ccsnoopaddr[31:IW+3];

    snoop_tag_match #(
        .WAYS (WAYS),
        .TW   (TW),
        .WW   (WW)
    ) u_match (
        .i_tag     (w_tag),
        .way_tag   (way_tag),
        .way_state (way_state),
        .o_hit     (w_hit),
        .o_way     (w_way),
        .o_state   (w_msi)
    );

    assign w_word    = way_data[w_way][bus.ccsnoopaddr[2]];
    assign w_hit_m   = w_hit && w_msi == M;
    assign w_snooped = bus.ccwait || r_state != SNP_IDLE;
    assign w_supply  = r_state == SNP_SUPPLY;
    assign w_inv_acc = r_inv | bus.ccinv;

    // ccwrite answers in the snoop cycle itself, straight from the lookup.
    always_comb begin
        bus.ccwrite = req_ccwrite;
        if (w_supply)
            bus.ccwrite = 1'b1;
        else if (r_state == SNP_IDLE && bus.ccwait)
            bus.ccwrite = w_hit_m;
    end

    assign bus.cctrans = req_cctrans;
    assign bus.dWEN    = w_supply ? 1'b1   : req_dWEN;
    assign bus.dREN    = w_snooped ? 1'b0  : req_dREN;
    assign bus.daddr   = w_supply ? r_addr : req_daddr;
    assign bus.dstore  = w_supply ? r_word : req_dstore;
    assign req_dwait   = w_snooped ? 1'b1  : bus.dwait;

    assign upd_en    = r_upd_en;
    assign upd_idx   = r_idx;
    assign upd_way   = r_way;
    assign upd_state = r_upd_state;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state     <= SNP_IDLE;
            r_way       <= '0;
            r_idx       <= '0;
            r_msi       <= I;
            r_word      <= '0;
            r_addr      <= '0;
            r_inv       <= 1'b0;
            r_upd_en    <= 1'b0;
            r_upd_state <= I;
        end else begin
            r_upd_en <= 1'b0;
            unique case (r_state)
                SNP_IDLE: begin
                    if (bus.ccwait) begin
                        r_way  <= w_way;
                        r_idx  <= snp_idx;
                        r_msi  <= w_hit ? w_msi : I;
                        r_word <= w_word;
                        r_addr <= bus.ccsnoopaddr;
                        r_inv  <= bus.ccinv;
                        if (w_hit_m) begin
                            r_state <= SNP_SUPPLY;
                        end else if (w_hit && w_msi == S && bus.ccinv) begin
                            r_state     <= SNP_UPDATE;
                            r_upd_en    <= 1'b1;
                            r_upd_state <= snoop_next_state(S, 1'b1);
                        end else begin
                            r_state <= SNP_HOLD;
                        end
                    end
                end
                SNP_SUPPLY: begin
                    // Early release abandons the transfer; the line stays dirty.
                    if (!bus.ccwait) begin
                        r_state <= SNP_IDLE;
                    end else begin
                        r_inv <= w_inv_acc;
                        if (!bus.dwait) begin
                            r_state     <= SNP_UPDATE;
                            r_upd_en    <= 1'b1;
                            r_upd_state <= snoop_next_state(r_msi, w_inv_acc);
                        end
                    end
                end
                SNP_UPDATE: begin
                    r_state <= SNP_HOLD;
                end
                SNP_HOLD: begin
                    if (!bus.ccwait)
                        r_state <= SNP_IDLE;
                end
                default: r_state <= SNP_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dcache_snoop_responder.sv
// Self-checking bench for dcache_snoop_responder against a set/way array model.
// Directed protocol scenarios followed by randomized snoops and pass-through.
module tb_dcache_snoop_responder;
    import cpu_types_pkg::*;

    logic CLK = 1'b0;
    logic nRST;
    always #5 CLK = ~CLK;

    dcache_snoop_responder_if bus ();

    logic        req_dWEN, req_dREN, req_cctrans, req_ccwrite;
    logic [31:0] req_daddr, req_dstore;
    logic        req_dwait;
    logic [2:0]  snp_idx;
    logic [1:0][25:0]      way_tag;
    logic [1:0][1:0]       way_state;
    logic [1:0][1:0][31:0] way_data;
    logic        upd_en;
    logic [2:0]  upd_idx;
    logic [0:0]  upd_way;
    logic [1:0]  upd_state;

    logic [25:0] m_tag [8][2];
    logic [1:0]  m_st  [8][2];
    logic [31:0] m_dat [8][2][2];

    int tests = 0;
    int fails = 0;

    dcache_snoop_responder dut (
        .CLK         (CLK),
        .nRST        (nRST),
        .bus         (bus.master),
        .req_dWEN    (req_dWEN),
        .req_dREN    (req_dREN),
        .req_cctrans (req_cctrans),
        .req_ccwrite (req_ccwrite),
        .req_daddr   (req_daddr),
        .req_dstore  (req_dstore),
        .req_dwait   (req_dwait),
        .snp_idx     (snp_idx),
        .way_tag     (way_tag),
        .way_state   (way_state),
        .way_data    (way_data),
        .upd_en      (upd_en),
        .upd_idx     (upd_idx),
        .upd_way     (upd_way),
        .upd_state   (upd_state)
    );

    // The array model plays the dcache tag/state/data RAM read port.
    always_comb begin
        for (int w = 0; w < 2; w++) begin
            way_tag[w]     = m_tag[snp_idx][w];
            way_state[w]   = m_st[snp_idx][w];
            way_data[w][0] = m_dat[snp_idx][w][0];
            way_data[w][1] = m_dat[snp_idx][w][1];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_pass(input string tag);
        chk({tag, "_dWEN"},   bus.dWEN,    req_dWEN);
        chk({tag, "_dREN"},   bus.dREN,    req_dREN);
        chk({tag, "_daddr"},  bus.daddr,   req_daddr);
        chk({tag, "_dstore"}, bus.dstore,  req_dstore);
        chk({tag, "_ccwr"},   bus.ccwrite, req_ccwrite);
        chk({tag, "_cctr"},   bus.cctrans, req_cctrans);
        chk({tag, "_dwait"},  req_dwait,   bus.dwait);
        chk({tag, "_upd"},    upd_en,      1'b0);
    endtask

    task automatic rand_req();
        req_dWEN    = 1'($urandom);
        req_dREN    = 1'($urandom);
        req_cctrans = 1'($urandom);
        req_ccwrite = 1'($urandom);
        req_daddr   = $urandom;
        req_dstore  = $urandom;
        bus.dwait   = 1'($urandom);
    endtask

    // One full snoop transaction; n = supply cycles for an M hit.
    task automatic snoop(input logic [31:0] a, input bit inv,
                         input bit rnd_inv, input int n, input int hold);
        int          si;
        int          hw;
        bit          hit;
        bit          upd;
        bit          acc;
        logic [25:0] tg;
        logic [1:0]  hs;
        logic [1:0]  ns;
        logic [31:0] wd;
        si  = int'(a[5:3]);
        tg  = a[31:6];
        hit = 0;
        hw  = 0;
        hs  = 2'd0;
        for (int w = 0; w < 2; w++) begin
            if (!hit && m_tag[si][w] == tg && m_st[si][w] != 2'd0) begin
                hit = 1;
                hw  = w;
                hs  = m_st[si][w];
            end
        end
        wd  = m_dat[si][hw][a[2]];
        acc = inv;
        upd = 0;
        ns  = 2'd0;

        @(negedge CLK);
        bus.ccwait      = 1'b1;
        bus.ccsnoopaddr = a;
        bus.ccinv       = inv;
        bus.dwait       = 1'($urandom);
        #1;
        chk("snp_ccwrite", bus.ccwrite, hit && hs == 2'd2);
        chk("snp_rdwait", req_dwait, 1'b1);
        chk("snp_dREN", bus.dREN, 1'b0);
        chk("snp_upd", upd_en, 1'b0);

        if (hit && hs == 2'd2) begin
            for (int k = 1; k <= n; k++) begin
                @(negedge CLK);
                bus.ccinv = rnd_inv ? 1'($urandom) : 1'b0;
                acc       = acc | bus.ccinv;
                bus.dwait = (k < n);
                #1;
                chk("sup_dWEN", bus.dWEN, 1'b1);
                chk("sup_dstore", bus.dstore, wd);
                chk("sup_daddr", bus.daddr, a);
                chk("sup_ccwrite", bus.ccwrite, 1'b1);
                chk("sup_dREN", bus.dREN, 1'b0);
            end
            upd = 1;
            ns  = acc ? 2'd0 : 2'd1;
        end else if (hit && hs == 2'd1 && inv) begin
            upd = 1;
            ns  = 2'd0;
        end

        @(negedge CLK);
        bus.ccinv = 1'b0;
        #1;
        chk("upd_en", upd_en, upd);
        chk("upd_dWEN", bus.dWEN, req_dWEN);
        if (upd) begin
            chk("upd_idx", upd_idx, si);
            chk("upd_way", upd_way, hw);
            chk("upd_state", upd_state, ns);
            m_st[si][hw] = ns;
        end
        for (int h = 0; h < hold; h++) begin
            @(negedge CLK);
            bus.dwait = 1'($urandom);
            #1;
            chk("hold_upd", upd_en, 1'b0);
            chk("hold_rdwait", req_dwait, 1'b1);
            chk("hold_dREN", bus.dREN, 1'b0);
        end
        @(negedge CLK);
        bus.ccwait = 1'b0;
        #1;
        chk("rel_rdwait", req_dwait, 1'b1);
        chk("rel_dREN", bus.dREN, 1'b0);
        @(negedge CLK);
        #1;
        chk_pass("after");
    endtask

    initial begin
        nRST            = 1'b0;
        bus.ccwait      = 1'b0;
        bus.ccinv       = 1'b0;
        bus.ccsnoopaddr = '0;
        bus.dwait       = 1'b0;
        req_dWEN        = 1'b0;
        req_dREN        = 1'b0;
        req_cctrans     = 1'b0;
        req_ccwrite     = 1'b0;
        req_daddr       = '0;
        req_dstore      = '0;
        for (int s = 0; s < 8; s++) begin
            for (int w = 0; w < 2; w++) begin
                m_tag[s][w]    = '0;
                m_st[s][w]     = 2'd0;
                m_dat[s][w][0] = '0;
                m_dat[s][w][1] = '0;
            end
        end

        #12;
        chk("rst_upd", upd_en, 1'b0);
        chk("rst_dWEN", bus.dWEN, 1'b0);
        chk("rst_ccwrite", bus.ccwrite, 1'b0);
        chk("rst_daddr", bus.daddr, 32'h0);
        chk("rst_dstore", bus.dstore, 32'h0);
        chk("rst_rdwait", req_dwait, 1'b0);
        @(negedge CLK);
        nRST = 1'b1;
        @(negedge CLK);
        #1;
        chk_pass("idle0");

        // Set 0: way0 other tag, way1 tag 1 dirty.
        m_tag[0][0]    = 26'd7;
        m_st[0][0]     = 2'd1;
        m_tag[0][1]    = 26'd1;
        m_st[0][1]     = 2'd2;
        m_dat[0][1][1] = 32'hDEAD_BEEF;
        m_dat[0][1][0] = 32'h1234_5678;

        snoop(32'h0000_0044, 1'b0, 1'b0, 3, 1);
        chk("m_to_s", m_st[0][1], 2'd1);

        m_st[0][1] = 2'd2;
        snoop(32'h0000_0044, 1'b1, 1'b0, 2, 0);

        m_st[0][1] = 2'd1;
        snoop(32'h0000_0040, 1'b1, 1'b0, 1, 2);

        snoop(32'h0000_0044, 1'b1, 1'b0, 1, 2);

        req_dREN = 1'b1;
        m_st[0][1] = 2'd2;
        snoop(32'h0000_0040, 1'b0, 1'b0, 2, 1);
        chk("rel_dREN1", bus.dREN, 1'b1);
        req_dREN = 1'b0;

        // Reset in the middle of a supply.
        m_st[0][1] = 2'd2;
        req_dWEN   = 1'b0;
        @(negedge CLK);
        bus.ccwait      = 1'b1;
        bus.ccsnoopaddr = 32'h0000_0044;
        bus.ccinv       = 1'b1;
        @(negedge CLK);
        bus.dwait = 1'b1;
        #1;
        chk("rst_sup_dWEN", bus.dWEN, 1'b1);
        #1;
        nRST = 1'b0;
        #1;
        chk("rst_mid_dWEN", bus.dWEN, 1'b0);
        chk("rst_mid_daddr", bus.daddr, req_daddr);
        chk("rst_mid_upd", upd_en, 1'b0);
        @(negedge CLK);
        bus.ccwait = 1'b0;
        bus.ccinv  = 1'b0;
        nRST       = 1'b1;
        #1;
        chk("rst_after_upd", upd_en, 1'b0);
        @(negedge CLK);
        #1;
        chk("rst_after_upd2", upd_en, 1'b0);
        chk_pass("rst_after");

        // Randomized cache contents and snoops.
        for (int s = 0; s < 8; s++) begin
            for (int w = 0; w < 2; w++) begin
                m_tag[s][w]    = 26'($urandom_range(0, 3));
                m_st[s][w]     = 2'($urandom_range(0, 2));
                m_dat[s][w][0] = $urandom;
                m_dat[s][w][1] = $urandom;
            end
        end
        for (int t = 0; t < 40; t++) begin
            logic [31:0] a;
            a = {26'($urandom_range(0, 3)), 3'($urandom),
                 1'($urandom), 2'b00};
            rand_req();
            snoop(a, 1'($urandom), 1'b1, $urandom_range(1, 4),
                  $urandom_range(0, 3));
            @(negedge CLK);
            rand_req();
            #1;
            chk_pass("rnd_pass");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
